// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for DIV/DIVU.
// One quotient bit per cycle. Operands are converted to magnitudes on
// accept, and signs are reapplied when the result registers are loaded.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        startE,
   input  logic        signedE,
   input  logic        cancelE,
   input  logic [31:0] aE,
   input  logic [31:0] bE,
   output logic        stall_divE,
   output logic        ready,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, stateNext;
   logic [4:0]  cnt;
   logic [32:0] rem;      // partial remainder
   logic [31:0] dvd;      // dividend bits leave at the top, quotient bits enter at the bottom
   logic [31:0] dvs;      // divisor magnitude
   logic [31:0] aRaw;     // unmodified dividend, returned as remainder on divide-by-zero
   logic        sa, sb, divZero;

   logic        accept, step;
   logic [33:0] remShift, diff;
   logic        qBit;
   logic [32:0] remStep;
   logic [31:0] quoStep, quoFinal, remFinal;

   assign accept = (state == IDLE) & startE & ~cancelE;
   assign step   = (state == BUSY) & ~cancelE;

   // Hazard request: held while an accepted op is in flight, dropped at once on flush
   assign stall_divE = (((state == IDLE) & startE) | (state == BUSY)) & ~cancelE;

   // One restoring step plus the sign-corrected view of its result
   always_comb begin
      remShift = {rem, dvd[31]};
      diff     = remShift - {2'b00, dvs};
      qBit     = ~diff[33];
      remStep  = qBit ? diff[32:0] : remShift[32:0];
      quoStep  = {dvd[30:0], qBit};
      quoFinal = (sa ^ sb) ? (~quoStep + 32'd1) : quoStep;
      remFinal = sa ? (~remStep[31:0] + 32'd1) : remStep[31:0];
   end

   // Next-state logic; DONE always returns to IDLE so startE there is ignored
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (startE && !cancelE) stateNext = BUSY;
         BUSY:    if (cancelE) stateNext = IDLE;
                  else if (cnt == 5'd31) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register and registered ready (high exactly while in DONE)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b0;
      end else begin
         state <= stateNext;
         ready <= (stateNext == DONE);
      end
   end

   // Operand capture, iteration, and result load on the final step
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rem     <= '0;
         dvd     <= '0;
         dvs     <= '0;
         aRaw    <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         divZero <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
      end else if (accept) begin
         dvd     <= (signedE & aE[31]) ? (~aE + 32'd1) : aE;
         dvs     <= (signedE & bE[31]) ? (~bE + 32'd1) : bE;
         sa      <= signedE & aE[31];
         sb      <= signedE & bE[31];
         divZero <= (bE == 32'd0);
         aRaw    <= aE;
         rem     <= '0;
         cnt     <= '0;
      end else if (step) begin
         rem <= remStep;
         dvd <= quoStep;
         cnt <= cnt + 5'd1;
         if (cnt == 5'd31) begin
            hi_o <= divZero ? aRaw : remFinal;
            lo_o <= divZero ? 32'hFFFF_FFFF : quoFinal;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized + directed scoreboard bench for div_unit.
module tb_div_unit;

   logic        clk, rst, startE, signedE, cancelE;
   logic [31:0] aE, bE;
   logic        stall_divE, ready;
   logic [31:0] hi_o, lo_o;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   res_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] heldHi = '0, heldLo = '0;
   logic rstPrev = 1'b1;

   div_unit dut (
      .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .cancelE(cancelE),
      .aE(aE), .bE(bE), .stall_divE(stall_divE), .ready(ready), .hi_o(hi_o), .lo_o(lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division semantics (truncating, C-like)
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      res_t   r;
      longint la, lb;
      if (b == 32'd0) begin
         r.lo = 32'hFFFF_FFFF;
         r.hi = a;
      end else if (s) begin
         la   = longint'($signed(a));
         lb   = longint'($signed(b));
         r.lo = 32'(la / lb);
         r.hi = 32'(la % lb);
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      return r;
   endfunction

   // Monitor: pops the scoreboard on ready, otherwise checks outputs hold
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rstPrev) begin
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_hi", hi_o, 32'd0);
            chk("rst_lo", lo_o, 32'd0);
            heldHi = '0;
            heldLo = '0;
         end else if (ready) begin
            checks++;
            if (expQ.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready: ready=1 with no pending op at %0t", $time);
            end else begin
               e = expQ.pop_front();
               chk("lo", lo_o, e.lo);
               chk("hi", hi_o, e.hi);
               heldHi = e.hi;
               heldLo = e.lo;
            end
         end else begin
            chk("hold_hi", hi_o, heldHi);
            chk("hold_lo", lo_o, heldLo);
         end
         rstPrev = rst;
      end
   end

   // kind: 0 = run to completion, 1 = cancel at cycle abortAt, 2 = reset at cycle abortAt
   // cycle 0 is the start cycle, cycle k is the k-th BUSY cycle
   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int kind, input int abortAt);
      int n;
      bit done;
      startE  = 1'b1;
      aE      = a;
      bE      = b;
      signedE = s;
      if (kind == 0) expQ.push_back(model(a, b, s));
      n    = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (kind != 0 && i == abortAt) begin
            if (kind == 1) cancelE = 1'b1;
            else rst = 1'b1;
         end
         @(negedge clk);
         if (kind != 0 && i == abortAt) begin
            if (kind == 1) chk("cancel_stall", 32'(stall_divE), 32'd0);
            done = 1'b1;
         end else if (stall_divE) n++;
         else done = 1'b1;
         @(posedge clk); #1;
         startE  = 1'b0;
         cancelE = 1'b0;
         rst     = 1'b0;
         aE      = $urandom;
         bE      = $urandom;
         signedE = 1'($urandom_range(0, 1));
      end
      if (kind == 0) begin
         chk("stall_len", 32'(n), 32'd33);
         chk("result_seen", 32'(expQ.size()), 32'd0);
      end else if (kind == 2) begin
         @(negedge clk);
         chk("rst_idle_stall", 32'(stall_divE), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] a, b;
      rst = 1'b1; startE = 1'b0; signedE = 1'b0; cancelE = 1'b0; aE = '0; bE = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", 32'(stall_divE), 32'd0);
      chk("post_rst_ready", 32'(ready), 32'd0);
      @(posedge clk); #1;

      // Start with cancel in IDLE must not begin an op
      startE = 1'b1; cancelE = 1'b1; aE = 32'd9; bE = 32'd3;
      @(negedge clk);
      chk("idle_cancel_stall", 32'(stall_divE), 32'd0);
      @(posedge clk); #1;
      startE = 1'b0; cancelE = 1'b0;
      @(negedge clk);
      chk("idle_cancel_still_idle", 32'(stall_divE), 32'd0);
      @(posedge clk); #1;

      // Directed cases
      runOp(32'd100, 32'd7, 1'b0, 0, 0);
      runOp(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
      runOp(32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
      runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
      runOp(32'd5, 32'd0, 1'b0, 0, 0);
      runOp(32'hFFFF_FFF0, 32'd0, 1'b1, 0, 0);
      runOp(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);

      // Cancel on the 10th BUSY cycle, restart two cycles later
      runOp(32'd1000, 32'd3, 1'b0, 1, 10);
      @(posedge clk); #1;
      runOp(32'd1000, 32'd3, 1'b0, 0, 0);

      // Back-to-back: second start in the cycle right after DONE
      runOp(32'hDEAD_BEEF, 32'd1234, 1'b0, 0, 0);
      runOp(32'h8765_4321, 32'h0000_0FFF, 1'b1, 0, 0);

      // Reset on the 20th BUSY cycle
      runOp(32'd77, 32'd5, 1'b0, 2, 20);

      // Randomized ops with mixed gaps
      for (int k = 0; k < 24; k++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2, 3: b = $urandom_range(1, 255);
            4:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         runOp(a, b, 1'($urandom_range(0, 1)), 0, 0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, reset, synchronous, active-high.
REQ-003 The block SHALL have the port `startE`: input, 1 bit, a DIV/DIVU instruction occupies the execute stage.
REQ-004 The block SHALL have the port `signedE`: input, 1 bit; 1 = DIV (signed), 0 = DIVU (unsigned); sampled with startE.
REQ-005 The block SHALL have the port `cancelE`: input, 1 bit, abandon any operation (pipeline flush / exception).
REQ-006 The block SHALL have the port `aE`: input, 32 bits, dividend; sampled with startE.
REQ-007 The block SHALL have the port `bE`: input, 32 bits, divisor; sampled with startE.
REQ-008 The block SHALL have the port `stall_divE`: output, 1 bit, combinational request to the hazard unit to hold stages F/D/E.
REQ-009 The block SHALL have the port `ready`: output, 1 bit, hi_o/lo_o hold a fresh result this cycle.
REQ-010 The block SHALL have the port `hi_o`: output, 32 bits, remainder, registered.
REQ-011 The block SHALL have the port `lo_o`: output, 32 bits, quotient, registered.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-013 In IDLE with startE=1 and cancelE=0, the block SHALL:
- latch |aE| and |bE| (the magnitude when signedE=1, the raw value otherwise);
- latch the sign flags sa=aE[31]&signedE and sb=bE[31]&signedE;
- latch a divide-by-zero flag (bE==0) and the raw aE;
- clear the 33-bit partial remainder and the counter;
- go to BUSY.
REQ-014 In IDLE with startE=0 or cancelE=1, the block SHALL remain in IDLE.
REQ-015 Each BUSY cycle SHALL perform one restoring-division step:
- shift the remainder left by one, bringing in the next dividend bit, MSB first;
- trial-subtract the divisor;
- if the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in quotient bit 0.
REQ-016 The counter SHALL increment once per BUSY cycle; after the step with counter==31 the block SHALL go to DONE and load hi_o/lo_o.
REQ-017 Sign correction SHALL be applied when hi_o/lo_o are loaded:
- lo_o = quotient, two's-complement negated iff sa^sb;
- hi_o = remainder, negated iff sa.
REQ-018 Divide by zero SHALL override REQ-017: lo_o=32'hFFFFFFFF and hi_o=the latched raw aE, for both DIV and DIVU.
REQ-019 The signed case 0x80000000 / 0xFFFFFFFF SHALL yield lo_o=0x80000000 and hi_o=0 with no special-casing; 32-bit magnitude arithmetic makes this fall out naturally.
REQ-020 In DONE, ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally; startE is ignored in DONE.
REQ-021 stall_divE SHALL equal ((IDLE & startE) | BUSY) & ~cancelE; it SHALL be 0 in DONE.
REQ-022 Latency SHALL be: start cycle (stall=1), then 32 BUSY cycles (stall=1), then the DONE cycle (stall=0, ready=1). stall_divE is therefore high for exactly 33 consecutive cycles.
REQ-023 cancelE=1 in BUSY SHALL force the next state to IDLE, with no ready pulse and hi_o/lo_o unchanged.
REQ-024 cancelE SHALL have no effect on state in DONE; ready still pulses that cycle and the results are written.
REQ-025 hi_o and lo_o SHALL change only on the BUSY->DONE transition or on reset; otherwise they hold their values.
REQ-026 ready SHALL be registered (asserted exactly when state==DONE); stall_divE is the only combinational output.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL go to IDLE and clear the counter, partial remainder, latched operands, sign flags, hi_o and lo_o to 0.
REQ-028 rst SHALL take priority over startE and cancelE in every state, including mid-BUSY.
REQ-029 After reset, outputs SHALL be: ready=0, hi_o=0, lo_o=0, and stall_divE=0 unless startE=1.

Verification
REQ-030 DIVU 100/7: startE=1 for one cycle -> stall_divE high 33 cycles; next cycle ready=1, lo_o=14, hi_o=2.
REQ-031 DIV -7/2 (aE=0xFFFFFFF9, bE=2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU with the same operands -> lo_o=0x7FFFFFFC, hi_o=1.
REQ-032 Overflow and zero divisor:
- DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0;
- DIVU 5/0 -> lo_o=0xFFFFFFFF, hi_o=5.
REQ-033 Cancel: cancelE=1 on the 10th BUSY cycle -> stall_divE=0 that cycle, no ready pulse, hi_o/lo_o keep the prior result; a start 2 cycles later completes correctly after 33 stall cycles.
REQ-034 Reset mid-operation: rst=1 on the 20th BUSY cycle -> next cycle IDLE, stall_divE=0 (startE=0), hi_o=lo_o=0, ready never pulses.
REQ-035 Back-to-back: a new startE the cycle after DONE -> accepted from IDLE; no gap other than the single DONE cycle; both results correct and the first result is held until the second DONE.
